// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_pkg
// Purpose  : Shared types and constants for the UART frame parser.
//            Holds the parser state encoding, the err_code values, the
//            default sync byte, and a helper that sizes buffer addresses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    // Parser states. DRAIN is the only state in which the output stream is live.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    // err_code values reported alongside err_valid.
    localparam logic [1:0] c_ERR_TIMEOUT = 2'b00;
    localparam logic [1:0] c_ERR_BAD_LEN = 2'b01;
    localparam logic [1:0] c_ERR_BAD_SUM = 2'b10;
    localparam logic [1:0] c_ERR_OVERRUN = 2'b11;

    // Frame start marker used when the instantiator does not override it.
    localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

    // Address width for a buffer of the given depth; never narrower than 1.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage : uart_frame_pkg
`default_nettype wire

// File: rtl/uart_frame_parser_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser_if
// Purpose  : Bundles the byte-strobe input, the payload valid/ready stream
//            and the error strobe of the UART frame parser.
// Ports    : rx_data/rx_ready   - byte strobes from the UART receiver
//            out_data/out_valid/out_last/out_ready - payload byte stream
//            pkt_len            - length of the frame being drained
//            err_valid/err_code - one-cycle error report
// Modports : master - the parser side; slave - the surrounding logic.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic [7:0] pkt_len;
    logic       err_valid;
    logic [1:0] err_code;

    modport master (
        input  rx_data, rx_ready, out_ready,
        output out_data, out_valid, out_last, pkt_len, err_valid, err_code
    );

    modport slave (
        output rx_data, rx_ready, out_ready,
        input  out_data, out_valid, out_last, pkt_len, err_valid, err_code
    );
endinterface : uart_frame_parser_if
`default_nettype wire

// File: rtl/uart_frame_buf.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_buf
// Purpose  : Payload store for one frame. DEPTH x 8 register array with one
//            synchronous write port and one combinational read port.
//            Storage has no reset; contents are only read after being written.
// Ports    : clk      - system clock
//            wr_en    - write strobe
//            wr_addr  - write address
//            wr_data  - write byte
//            rd_addr  - read address
//            rd_data  - byte at rd_addr (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : uart_frame_buf
`default_nettype wire

// File: rtl/uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_parser
// Purpose  : Framing stage behind a UART receiver. Hunts for SYNC_BYTE,
//            collects a length-prefixed payload, checks the additive checksum
//            (LEN + sum of payload, mod 256) and releases good payloads on a
//            valid/ready byte stream. Bad frames raise a one-cycle err_valid.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            bus      - uart_frame_parser_if.master (rx strobes, output
//                       stream, pkt_len, error strobe)
// Config   : `define UART_FRAME_TIMEOUT_EN builds an inter-byte timeout
//            counter (TIMEOUT_CYCLES). Without it the parser waits forever
//            mid-frame and err_code 00 is never produced.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = c_SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 110000
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_frame_parser_if.master bus
);

    localparam int ADDR_W = addr_width(MAX_LEN);

    state_t      r_state,     w_state_nxt;
    logic [7:0]  r_sum,       w_sum_nxt;
    logic [7:0]  r_idx,       w_idx_nxt;
    logic [7:0]  r_rd_idx,    w_rd_idx_nxt;
    logic [7:0]  r_pkt_len,   w_pkt_len_nxt;
    logic [7:0]  r_out_data,  w_out_data_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic        r_out_last,  w_out_last_nxt;
    logic        r_err_valid, w_err_valid_nxt;
    logic [1:0]  r_err_code,  w_err_code_nxt;

    logic              w_buf_we;
    logic [7:0]        w_buf_rdata;
    logic [7:0]        w_rd_idx_inc;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_timeout;

    // ------------------------------------------------------------------
    // Payload buffer. The read address looks one byte ahead: in CSUM it
    // points at byte 0 so out_data is ready on entry to DRAIN; in DRAIN it
    // points at the byte that follows the one currently presented.
    // ------------------------------------------------------------------
    assign w_rd_idx_inc = r_rd_idx + 8'd1;
    assign w_rd_addr    = (r_state == ST_DRAIN) ? w_rd_idx_inc[ADDR_W-1:0] : '0;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_buf_we),
        .wr_addr (r_idx[ADDR_W-1:0]),
        .wr_data (bus.rx_data),
        .rd_addr (w_rd_addr),
        .rd_data (w_buf_rdata)
    );

    // ------------------------------------------------------------------
    // Inter-byte timeout
    // ------------------------------------------------------------------
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_in_frame;

    assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                        (r_state == ST_CSUM);
    assign w_timeout  = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Cleared on every accepted byte and whenever the parser is (or is about
    // to be) outside the frame-collecting states.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo_cnt <= '0;
        end else if (!w_in_frame || bus.rx_ready || w_timeout ||
                     (w_state_nxt == ST_IDLE)) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end
`else
    // No counter in this build; the parameter is kept only so every build
    // shares one instantiation template.
    localparam int c_timeout_unused = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_sum_nxt       = r_sum;
        w_idx_nxt       = r_idx;
        w_rd_idx_nxt    = r_rd_idx;
        w_pkt_len_nxt   = r_pkt_len;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_err_valid_nxt = 1'b0;
        w_err_code_nxt  = r_err_code;
        w_buf_we        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Non-sync bytes are dropped without comment.
                if (bus.rx_ready && (bus.rx_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_LEN;
                end
            end

            ST_LEN: begin
                if (bus.rx_ready) begin
                    if ((bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_LEN))) begin
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = c_ERR_BAD_LEN;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_pkt_len_nxt = bus.rx_data;
                        w_sum_nxt     = bus.rx_data;
                        w_idx_nxt     = 8'd0;
                        w_state_nxt   = ST_PAYLOAD;
                    end
                end else if (w_timeout) begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = c_ERR_TIMEOUT;
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_PAYLOAD: begin
                if (bus.rx_ready) begin
                    w_buf_we  = 1'b1;
                    w_sum_nxt = r_sum + bus.rx_data;
                    w_idx_nxt = r_idx + 8'd1;
                    if (r_idx == (r_pkt_len - 8'd1)) begin
                        w_state_nxt = ST_CSUM;
                    end
                end else if (w_timeout) begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = c_ERR_TIMEOUT;
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_CSUM: begin
                if (bus.rx_ready) begin
                    if (bus.rx_data == r_sum) begin
                        // Present byte 0 in the very next cycle.
                        w_rd_idx_nxt    = 8'd0;
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = w_buf_rdata;
                        w_out_last_nxt  = (r_pkt_len == 8'd1);
                        w_state_nxt     = ST_DRAIN;
                    end else begin
                        w_err_valid_nxt = 1'b1;
                        w_err_code_nxt  = c_ERR_BAD_SUM;
                        w_state_nxt     = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = c_ERR_TIMEOUT;
                    w_state_nxt     = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                // The receiver cannot be stalled, so a byte arriving now is
                // lost; report it but leave the output stream untouched.
                if (bus.rx_ready) begin
                    w_err_valid_nxt = 1'b1;
                    w_err_code_nxt  = c_ERR_OVERRUN;
                end
                if (r_out_valid && bus.out_ready) begin
                    if (r_out_last) begin
                        w_out_valid_nxt = 1'b0;
                        w_out_last_nxt  = 1'b0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        w_rd_idx_nxt   = w_rd_idx_inc;
                        w_out_data_nxt = w_buf_rdata;
                        w_out_last_nxt = (w_rd_idx_inc == (r_pkt_len - 8'd1));
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= 8'd0;
            r_idx       <= 8'd0;
            r_rd_idx    <= 8'd0;
            r_pkt_len   <= 8'd0;
            r_out_data  <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            r_state     <= w_state_nxt;
            r_sum       <= w_sum_nxt;
            r_idx       <= w_idx_nxt;
            r_rd_idx    <= w_rd_idx_nxt;
            r_pkt_len   <= w_pkt_len_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_last  <= w_out_last_nxt;
            r_err_valid <= w_err_valid_nxt;
            r_err_code  <= w_err_code_nxt;
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.pkt_len   = r_pkt_len;
    assign bus.err_valid = r_err_valid;
    assign bus.err_code  = r_err_code;

endmodule : uart_frame_parser
`default_nettype wire

// File: tb/tb_uart_frame_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_parser
// Purpose  : Self-checking bench for uart_frame_parser: a table of directed
//            frames, hand-written stall/overrun/reset/timeout sequences, and
//            a randomized byte stream compared against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_frame_parser;
    import uart_frame_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 100;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    int   cyc;
    int   last_stamp;
    logic rnd_ready;

    uart_frame_parser_if bus ();

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [7:0] plen;
        int         stamp;
    } out_rec_t;
    typedef struct {
        logic [1:0] code;
        int         stamp;
    } err_rec_t;

    out_rec_t out_q[$];
    err_rec_t err_q[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.out_valid && bus.out_ready)
                out_q.push_back('{bus.out_data, bus.out_last, bus.pkt_len, cyc});
            if (bus.err_valid)
                err_q.push_back('{bus.err_code, cyc});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // All driving happens 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        last_stamp   = cyc;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    task automatic clear_mon();
        out_q.delete();
        err_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string        name;
        int           n_in;
        logic [159:0] in_b;    // bytes, first byte most significant
        int           n_out;
        logic [127:0] out_b;   // expected payload, first byte most significant
        int           n_err;
        logic [1:0]   err;
    } vec_t;

    vec_t vecs[7];

    // ---------------- random stream model ----------------
    logic [7:0] stream[$];
    int         drain_at[$];
    out_rec_t   exp_out[$];
    logic [1:0] exp_err[$];

    // Walks the whole byte stream frame by frame using the framing rules.
    function automatic void model();
        int i;
        int n;
        int len;
        int total;
        i = 0;
        n = stream.size();
        drain_at.delete();
        exp_out.delete();
        exp_err.delete();
        for (int k = 0; k < n; k++) drain_at.push_back(-1);
        while (i < n) begin
            if (stream[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(stream[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                exp_err.push_back(2'b01);
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            total = len;
            for (int j = 0; j < len; j++) total += int'(stream[i+2+j]);
            if (int'(stream[i+2+len]) == total % 256) begin
                for (int j = 0; j < len; j++)
                    exp_out.push_back('{stream[i+2+j], (j == len - 1), 8'(len), 0});
                drain_at[i+2+len] = exp_out.size();
            end else begin
                exp_err.push_back(2'b10);
            end
            i += len + 3;
        end
    endfunction

    initial begin
        int n_cmp;
        int stable_bad;
        int ovr_stamp;
        int s;
        int kind;
        int len;
        int tot;
        int t;
        logic [7:0] b;

        errors       = 0;
        checks       = 0;
        rnd_ready    = 1'b0;
        reset_n      = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{"good",      6, 160'hA5_03_11_22_33_69, 3, 128'h11_22_33, 0, 2'b00};
        vecs[1] = '{"bad_csum",  6, 160'hA5_03_11_22_33_6A, 0, 128'h0,        1, 2'b10};
        vecs[2] = '{"good_after",5, 160'hA5_02_11_22_35,    2, 128'h11_22,    0, 2'b00};
        vecs[3] = '{"len0",      2, 160'hA5_00,             0, 128'h0,        1, 2'b01};
        vecs[4] = '{"len17",     2, 160'hA5_11,             0, 128'h0,        1, 2'b01};
        vecs[5] = '{"len16",    19,
                    160'hA5_10_0102030405060708090A0B0C0D0E0F10_98,
                    16, 128'h0102030405060708090A0B0C0D0E0F10, 0, 2'b00};
        vecs[6] = '{"garbage",   7, 160'h00_FF_5A_A5_01_7E_7F, 1, 128'h7E,     0, 2'b00};

        // ---- reset values ----
        #22;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data",  bus.out_data,  0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_pkt_len",   bus.pkt_len,   0);
        chk("rst_err_valid", bus.err_valid, 0);
        chk("rst_err_code",  bus.err_code,  0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // ---- directed table ----
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            bus.out_ready = 1'b1;
            for (int i = 0; i < vecs[v].n_in; i++)
                send_byte(vecs[v].in_b[(vecs[v].n_in - 1 - i)*8 +: 8]);
            s = last_stamp;
            idle(25);
            chk({vecs[v].name, "_nout"}, out_q.size(), vecs[v].n_out);
            n_cmp = (out_q.size() < vecs[v].n_out) ? out_q.size() : vecs[v].n_out;
            for (int i = 0; i < n_cmp; i++) begin
                chk($sformatf("%s_data%0d", vecs[v].name, i), out_q[i].data,
                    vecs[v].out_b[(vecs[v].n_out - 1 - i)*8 +: 8]);
                chk($sformatf("%s_last%0d", vecs[v].name, i), out_q[i].last,
                    (i == vecs[v].n_out - 1));
                chk($sformatf("%s_plen%0d", vecs[v].name, i), out_q[i].plen, vecs[v].n_out);
                chk($sformatf("%s_cycle%0d", vecs[v].name, i), out_q[i].stamp, s + 1 + i);
            end
            chk({vecs[v].name, "_nerr"}, err_q.size(), vecs[v].n_err);
            if (vecs[v].n_err > 0 && err_q.size() > 0) begin
                chk({vecs[v].name, "_errcode"}, err_q[0].code, vecs[v].err);
                chk({vecs[v].name, "_errcycle"}, err_q[0].stamp, s + 1);
            end
        end

        // ---- backpressure with an overrun byte during the stall ----
        clear_mon();
        bus.out_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        stable_bad = 0;
        ovr_stamp  = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 8) begin
                bus.rx_data  = 8'hA5;
                bus.rx_ready = 1'b1;
                ovr_stamp    = cyc;
            end
            @(negedge clk);
            if (!(bus.out_valid === 1'b1 && bus.out_data === 8'h11 &&
                  bus.out_last === 1'b0 && bus.pkt_len === 8'd3))
                stable_bad++;
            @(posedge clk);
            #1;
            bus.rx_ready = 1'b0;
        end
        chk("stall_unstable_cycles", stable_bad, 0);
        chk("stall_out_data", bus.out_data, 8'h11);
        chk("ovr_nerr", err_q.size(), 1);
        if (err_q.size() > 0) begin
            chk("ovr_code",  err_q[0].code,  2'b11);
            chk("ovr_cycle", err_q[0].stamp, ovr_stamp + 1);
        end
        bus.out_ready = 1'b1;
        idle(8);
        chk("ovr_nout", out_q.size(), 3);
        if (out_q.size() == 3) begin
            chk("ovr_d0", out_q[0].data, 8'h11);
            chk("ovr_d1", out_q[1].data, 8'h22);
            chk("ovr_d2", {out_q[2].data, 7'd0, out_q[2].last}, {8'h33, 8'h01});
        end
        chk("ovr_nerr_after", err_q.size(), 1);

        // ---- asynchronous reset mid-payload ----
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data",  bus.out_data,  0);
        chk("arst_pkt_len",   bus.pkt_len,   0);
        chk("arst_err_code",  bus.err_code,  0);
        idle(2);
        reset_n = 1'b1;
        idle(1);
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h35);
        idle(6);
        chk("arst_nout", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("arst_d0", out_q[0].data, 8'h11);
            chk("arst_d1", out_q[1].data, 8'h22);
        end
        chk("arst_nerr", err_q.size(), 0);

        // ---- inter-byte timeout ----
        clear_mon();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        s = last_stamp;
        idle(110);
`ifdef UART_FRAME_TIMEOUT_EN
        chk("tmo_nerr", err_q.size(), 1);
        if (err_q.size() > 0) begin
            chk("tmo_code",  err_q[0].code,  2'b00);
            chk("tmo_cycle", err_q[0].stamp, s + 1 + TMO);
        end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        idle(5);
        chk("tmo_next_nout", out_q.size(), 1);
        if (out_q.size() > 0) chk("tmo_next_d0", out_q[0].data, 8'h7E);
`else
        chk("notmo_nerr", err_q.size(), 0);
        send_byte(8'h22); send_byte(8'h35);
        idle(5);
        chk("notmo_nout", out_q.size(), 2);
        if (out_q.size() == 2) begin
            chk("notmo_d0", out_q[0].data, 8'h11);
            chk("notmo_d1", out_q[1].data, 8'h22);
        end
`endif

        // ---- randomized stream vs. model ----
        stream.delete();
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                len = $urandom_range(1, MAX_LEN);
                stream.push_back(8'hA5);
                stream.push_back(8'(len));
                tot = len;
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom);
                    stream.push_back(b);
                    tot += int'(b);
                end
                b = 8'(tot);
                if (kind >= 5) b = b + 8'($urandom_range(1, 255));
                stream.push_back(b);
            end else if (kind == 7) begin
                stream.push_back(8'hA5);
                if ($urandom_range(0, 1) == 0) stream.push_back(8'h00);
                else stream.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                for (int j = 0; j < $urandom_range(1, 4); j++) begin
                    b = 8'($urandom);
                    if (b == 8'hA5) b = 8'h00;
                    stream.push_back(b);
                end
            end
        end
        model();
        clear_mon();
        rnd_ready = 1'b1;
        for (int i = 0; i < stream.size(); i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(stream[i]);
            if (drain_at[i] >= 0) begin
                t = 0;
                while (out_q.size() < drain_at[i] && t < 400) begin
                    tick();
                    t++;
                end
                if (t >= 400) chk($sformatf("rnd_drain_wait_%0d", i), out_q.size(), drain_at[i]);
            end
        end
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        idle(30);
        chk("rnd_nout", out_q.size(), exp_out.size());
        n_cmp = (out_q.size() < exp_out.size()) ? out_q.size() : exp_out.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("rnd_out%0d", i), {out_q[i].data, out_q[i].plen, 7'd0, out_q[i].last},
                {exp_out[i].data, exp_out[i].plen, 7'd0, exp_out[i].last});
        chk("rnd_nerr", err_q.size(), exp_err.size());
        n_cmp = (err_q.size() < exp_err.size()) ? err_q.size() : exp_err.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("rnd_err%0d", i), err_q[i].code, exp_err[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_frame_parser
`default_nettype wire

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's one-cycle `rx_data`/`rx_ready` byte strobes and hunts for a sync byte. It then collects a length-prefixed payload into a local buffer and checks an 8-bit additive checksum. A good frame's payload is released on a valid/ready byte stream with a last flag; every bad frame is reported on an error strobe.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, maximum payload bytes (1..255)
- `TIMEOUT_CYCLES`, 110000, inter-byte timeout in clocks (only with timeout feature)
- `clk`  in  1  system clock
- `reset_n`  in  1  reset; asynchronous, active-low
- `rx_data`  in  8  received byte from UART receiver
- `rx_ready`  in  1  one-cycle strobe, `rx_data` valid; no backpressure possible
- `out_data`  out  8  payload byte
- `out_valid`  out  1  `out_data` valid
- `out_last`  out  1  marks final payload byte
- `out_ready`  in  1  consumer accepts byte
- `pkt_len`  out  8  payload length of frame being drained
- `err_valid`  out  1  one-cycle error strobe
- `err_code`  out  2  00 timeout, 01 bad length, 10 bad checksum, 11 overrun

## Operation
- Frame: SYNC_BYTE, LEN, LEN payload bytes, CSUM. CSUM = (LEN + sum of payload) mod 256.
- IDLE
  - A byte equal to SYNC_BYTE moves to LEN.
  - Any other byte is discarded silently, with no error.
- LEN
  - LEN == 0 or LEN > MAX_LEN: err 01, go to IDLE.
  - Otherwise latch `pkt_len`, set sum = LEN and idx = 0, go to PAYLOAD.
- PAYLOAD
  - Write buf[idx], sum += byte (8-bit wrap), idx++.
  - After byte LEN-1 is written, go to CSUM.
- CSUM
  - Byte == sum: go to DRAIN with rd_idx = 0.
  - Otherwise: err 10, go to IDLE, and discard the buffer.
- DRAIN
  - `out_valid` = 1, `out_data` = buf[rd_idx], `out_last` = (rd_idx == pkt_len-1).
  - `out_valid && out_ready` advances rd_idx.
  - The handshake on the last byte returns to IDLE.
- Any `rx_ready` during DRAIN: byte dropped, err 11. State and output are unaffected.
- A SYNC_BYTE value inside LEN, PAYLOAD or CSUM is treated as data; there is no resync.
- Errors and resets never emit partial payload on the output.

## Timing
- Reset values: state IDLE; `out_data` 0; `out_valid` 0; `out_last` 0; `pkt_len` 0; `err_valid` 0; `err_code` 00; sum, idx and rd_idx 0. Buffer contents are don't-care.
- A byte is consumed in the cycle `rx_ready` = 1. The state updates on that edge.
- `err_valid` is high for exactly the cycle after the offending byte or timeout. `err_code` holds its value until the next error.
- `out_valid` rises in the first cycle after the CSUM byte's edge (1-cycle latency).
- While `out_valid && !out_ready`, `out_data`, `out_last` and `pkt_len` are held stable.
- Back-to-back ready: one payload byte per clock.
- `out_valid` deasserts in the cycle after the last handshake. A new frame may start in that same IDLE cycle.
- `reset_n` low at any time, including mid-frame or mid-drain: all outputs return to reset values immediately (asynchronous).

## Configuration
- Macro `UART_FRAME_TIMEOUT_EN`.
- Defined
  - A counter runs in LEN, PAYLOAD and CSUM, cleared on every accepted byte and on entry to IDLE.
  - Reaching TIMEOUT_CYCLES-1 gives err 00 and a return to IDLE.
  - If a byte and expiry occur in the same cycle, the byte wins and no timeout is raised.
- Undefined
  - No counter is built and `TIMEOUT_CYCLES` is ignored.
  - The parser waits indefinitely mid-frame. Error code 00 is never produced.

## Structure
- Package `uart_frame_pkg`:
  - state encoding (IDLE, LEN, PAYLOAD, CSUM, DRAIN)
  - `err_code` constants
  - default SYNC_BYTE value
- Sub-module `uart_frame_buf`: MAX_LEN x 8 register array with one synchronous write port, one combinational read port and no reset on storage.
- The parser holds the FSM, sum, indices, timeout counter and output registers.

## Test plan
- Good frame: A5 03 11 22 33 69, `out_ready` = 1 → out 11, 22, 33 on consecutive clocks, `out_last` on 33, `pkt_len` = 3, no error.
- Bad checksum: A5 03 11 22 33 6A → `err_valid` one cycle with code 10, no `out_valid`. A following good frame is then parsed correctly.
- Length bounds: A5 00 → err 01. A5 11 with MAX_LEN = 16 → err 01. A5 10 with 16 bytes + correct CSUM → 16 bytes out.
- Backpressure and overrun: good frame with `out_ready` = 0 for 20 cycles → `out_data` = 11 held stable. A byte strobed during the stall → err 11, output unchanged.
- Garbage and reset: 00 FF 5A before A5 01 7E 7F → only 7E output. `reset_n` pulsed mid-payload → outputs at reset values, next frame parses normally.
- Timeout (macro defined, TIMEOUT_CYCLES = 100): A5 02 11 then idle 100 cycles → err 00, state IDLE. Same test without the macro → no error, and completing the frame with 22 35 outputs 11 22.
